mure_retire_scheduler: RTL and testbench

- Sequencing controller for the multiple-retirement front end.
- Commit ports push a group of NRET slots per cycle into lock-stepped per-port FIFOs; this block walks the valid slots of the head group in program order (slot 0 first), presents one slot per handshake to the downstream itype/encoder pipeline, and pops all FIFOs together once the group is fully issued.
- Drives the slot-select mux, replacing free-running counter sequencing with valid-aware, backpressured scheduling.

---
 rtl/mure_retire_scheduler.sv | 144 ++++++++++++++
 tb/tb_mure_retire_scheduler.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mure_retire_scheduler.sv
// Retire-slot sequencer: walks the valid slots of the head commit group in ascending order
// and pops the lock-stepped FIFOs once the group is issued. Optional counters: MURE_SCHED_STATS_EN.
module mure_retire_scheduler #(
  parameter  int unsigned NRET = 2,
  localparam int unsigned SELW = $clog2(NRET)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            flush_i,
  input  logic            group_avail_i,
  input  logic [NRET-1:0] slot_valid_i,
  input  logic            ready_i,
  output logic            valid_o,
  output logic [SELW-1:0] sel_o,
  output logic            last_o,
  output logic            pop_o,
  output logic            busy_o,
  input  logic            clr_stats_i,
  output logic [15:0]     stall_cnt_o,
  output logic [15:0]     empty_grp_cnt_o
);

  typedef enum logic {IDLE, EMIT} state_e;

  state_e          state_q, state_d;
  logic [NRET-1:0] mask_q, mask_d;
  logic [NRET-1:0] rem;
  logic            valid_q, valid_d;
  logic [SELW-1:0] sel_q, sel_d;
  logic            last_q, last_d;
  logic            pop;
  logic            empty_drop;

  function automatic logic [SELW-1:0] lowest_idx(input logic [NRET-1:0] v);
    lowest_idx = '0;
    for (int unsigned i = NRET; i > 0; i--) begin
      if (v[i-1]) lowest_idx = SELW'(i - 1);
    end
  endfunction

  function automatic logic at_most_one(input logic [NRET-1:0] v);
    return (v & (v - NRET'(1))) == '0;
  endfunction

  always_comb begin
    state_d    = state_q;
    mask_d     = mask_q;
    valid_d    = valid_q;
    sel_d      = sel_q;
    last_d     = last_q;
    pop        = 1'b0;
    empty_drop = 1'b0;
    // Slots above the one being presented; lower bits were cleared as they issued.
    rem        = mask_q & ~(NRET'(1) << sel_q);
    if (flush_i) begin
      state_d = IDLE;
      valid_d = 1'b0;
      last_d  = 1'b0;
      mask_d  = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (group_avail_i) begin
            if (slot_valid_i == '0) begin
              pop        = 1'b1;
              empty_drop = 1'b1;
            end else begin
              mask_d  = slot_valid_i;
              sel_d   = lowest_idx(slot_valid_i);
              last_d  = at_most_one(slot_valid_i);
              valid_d = 1'b1;
              state_d = EMIT;
            end
          end
        end
        EMIT: begin
          if (ready_i) begin
            if (last_q) begin
              pop     = 1'b1;
              valid_d = 1'b0;
              last_d  = 1'b0;
              mask_d  = '0;
              state_d = IDLE;
            end else begin
              mask_d = rem;
              sel_d  = lowest_idx(rem);
              last_d = at_most_one(rem);
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      mask_q  <= '0;
      valid_q <= 1'b0;
      sel_q   <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      valid_q <= valid_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
    end
  end

  assign valid_o = valid_q;
  assign sel_o   = sel_q;
  assign last_o  = last_q;
  assign busy_o  = (state_q == EMIT);
  // No pop may escape while reset is held, even for an empty head group.
  assign pop_o   = pop & rst_ni;

`ifdef MURE_SCHED_STATS_EN
  logic [15:0] stall_cnt_q, empty_cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_cnt_q <= '0;
      empty_cnt_q <= '0;
    end else if (clr_stats_i) begin
      stall_cnt_q <= '0;
      empty_cnt_q <= '0;
    end else begin
      if (valid_q && !ready_i && !flush_i && stall_cnt_q != '1) stall_cnt_q <= stall_cnt_q + 16'd1;
      if (empty_drop && empty_cnt_q != '1) empty_cnt_q <= empty_cnt_q + 16'd1;
    end
  end

  assign stall_cnt_o     = stall_cnt_q;
  assign empty_grp_cnt_o = empty_cnt_q;
`else
  logic unused_stats;
  assign unused_stats    = clr_stats_i ^ empty_drop;
  assign stall_cnt_o     = '0;
  assign empty_grp_cnt_o = '0;
`endif

endmodule

// File: tb/tb_mure_retire_scheduler.sv
// Scoreboard bench: NRET=2 and NRET=4 schedulers driven with directed groups.
module tb_mure_retire_scheduler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        a_flush, a_avail, a_rdy, a_clr;
  logic [1:0]  a_sv;
  logic        a_valid, a_last, a_pop, a_busy;
  logic [0:0]  a_sel;
  logic [15:0] a_stall, a_empty;

  logic        b_flush, b_avail, b_rdy, b_clr;
  logic [3:0]  b_sv;
  logic        b_valid, b_last, b_pop, b_busy;
  logic [1:0]  b_sel;
  logic [15:0] b_stall, b_empty;

  mure_retire_scheduler #(.NRET(2)) dut2 (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(a_flush), .group_avail_i(a_avail),
    .slot_valid_i(a_sv), .ready_i(a_rdy), .valid_o(a_valid), .sel_o(a_sel),
    .last_o(a_last), .pop_o(a_pop), .busy_o(a_busy), .clr_stats_i(a_clr),
    .stall_cnt_o(a_stall), .empty_grp_cnt_o(a_empty)
  );

  mure_retire_scheduler #(.NRET(4)) dut4 (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(b_flush), .group_avail_i(b_avail),
    .slot_valid_i(b_sv), .ready_i(b_rdy), .valid_o(b_valid), .sel_o(b_sel),
    .last_o(b_last), .pop_o(b_pop), .busy_o(b_busy), .clr_stats_i(b_clr),
    .stall_cnt_o(b_stall), .empty_grp_cnt_o(b_empty)
  );

`ifdef MURE_SCHED_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  typedef struct packed {
    logic [1:0] sel;
    logic       last;
    logic       pop;
  } beat_t;

  beat_t qa[$];
  beat_t qb[$];
  int n_cmp = 0;
  int n_bad = 0;
  int nb_beats = 0;

  function automatic beat_t mk(input int sel, input bit last, input bit pop);
    beat_t b;
    b.sel  = 2'(sel);
    b.last = last;
    b.pop  = pop;
    return b;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every accepted beat must match the next expected beat.
  always @(negedge clk) begin
    beat_t e;
    if (rst_n) begin
      if (a_valid && a_rdy && !a_flush) begin
        if (qa.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL a_unexpected_beat: got sel %0d, expected no beat", a_sel);
        end else begin
          e = qa.pop_front();
          chk("a_sel", int'(a_sel), int'(e.sel));
          chk("a_last", int'(a_last), int'(e.last));
          chk("a_pop", int'(a_pop), int'(e.pop));
        end
      end
      if (b_valid && b_rdy && !b_flush) begin
        nb_beats++;
        if (qb.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL b_unexpected_beat: got sel %0d, expected no beat", b_sel);
        end else begin
          e = qb.pop_front();
          chk("b_sel", int'(b_sel), int'(e.sel));
          chk("b_last", int'(b_last), int'(e.last));
          chk("b_pop", int'(b_pop), int'(e.pop));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic run_b(input logic [3:0] sv, input int nbeats);
    b_avail = 1'b1; b_sv = sv; b_rdy = 1'b1;
    tick();
    repeat (nbeats - 1) tick();
    chk("b_pop_last", int'(b_pop), 1);
    b_avail = 1'b0;
    tick();
    chk("b_idle_after", int'(b_valid), 0);
  endtask

  initial begin
    int nb0;
    rst_n = 1'b0;
    a_flush = 0; a_avail = 0; a_rdy = 0; a_clr = 0; a_sv = '0;
    b_flush = 0; b_avail = 0; b_rdy = 0; b_clr = 0; b_sv = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", int'(a_valid), 0);
    chk("rst_sel", int'(a_sel), 0);
    chk("rst_last", int'(a_last), 0);
    chk("rst_pop", int'(a_pop), 0);
    chk("rst_busy", int'(a_busy), 0);
    chk("rst_stall", int'(a_stall), 0);
    chk("rst_empty", int'(a_empty), 0);
    chk("rst_b_valid", int'(b_valid), 0);
    rst_n = 1'b1;
    tick();

    // 2'b11, always ready
    a_avail = 1; a_sv = 2'b11; a_rdy = 1;
    qa.push_back(mk(0, 0, 0)); qa.push_back(mk(1, 1, 1));
    #1 chk("t1_not_yet_valid", int'(a_valid), 0);
    tick();
    chk("t1_valid", int'(a_valid), 1);
    chk("t1_busy", int'(a_busy), 1);
    tick();
    chk("t2_sel", int'(a_sel), 1);
    chk("t2_pop", int'(a_pop), 1);
    a_avail = 0;
    tick();
    chk("t3_valid", int'(a_valid), 0);
    chk("t3_busy", int'(a_busy), 0);

    // 3-cycle stall at slot 0
    a_avail = 1; a_sv = 2'b11; a_rdy = 0;
    qa.push_back(mk(0, 0, 0)); qa.push_back(mk(1, 1, 1));
    tick();
    for (int i = 0; i < 3; i++) begin
      chk("stall_valid", int'(a_valid), 1);
      chk("stall_sel", int'(a_sel), 0);
      chk("stall_pop", int'(a_pop), 0);
      tick();
    end
    chk("stall_cnt", int'(a_stall), STATS ? 3 : 0);
    a_rdy = 1;
    tick();
    chk("stall_end_pop", int'(a_pop), 1);
    a_avail = 0;
    tick();
    chk("stall_end_idle", int'(a_valid), 0);
    a_clr = 1;
    tick();
    a_clr = 0;
    chk("clr_stall", int'(a_stall), 0);

    // empty group
    a_avail = 1; a_sv = 2'b00;
    #1;
    chk("empty_pop", int'(a_pop), 1);
    chk("empty_valid", int'(a_valid), 0);
    tick();
    a_avail = 0;
    #1;
    chk("empty_valid_after", int'(a_valid), 0);
    chk("empty_pop_after", int'(a_pop), 0);
    chk("empty_cnt", int'(a_empty), STATS ? 1 : 0);
    a_avail = 1; a_clr = 1;
    tick();
    a_avail = 0; a_clr = 0;
    chk("clr_beats_incr", int'(a_empty), 0);

    // flush on the last-slot handshake
    a_avail = 1; a_sv = 2'b11; a_rdy = 1;
    qa.push_back(mk(0, 0, 0));
    tick();
    tick();
    chk("fl_sel", int'(a_sel), 1);
    chk("fl_last", int'(a_last), 1);
    a_flush = 1;
    #1 chk("fl_pop", int'(a_pop), 0);
    tick();
    a_flush = 0;
    chk("fl_valid", int'(a_valid), 0);
    chk("fl_busy", int'(a_busy), 0);
    qa.push_back(mk(0, 0, 0)); qa.push_back(mk(1, 1, 1));
    tick();
    chk("fl_restart_sel", int'(a_sel), 0);
    tick();
    a_avail = 0;
    tick();

    // async reset mid-EMIT
    a_avail = 1; a_sv = 2'b11; a_rdy = 0;
    tick();
    chk("rs_pre_valid", int'(a_valid), 1);
    rst_n = 0;
    #1;
    chk("rs_valid", int'(a_valid), 0);
    chk("rs_sel", int'(a_sel), 0);
    chk("rs_pop", int'(a_pop), 0);
    chk("rs_busy", int'(a_busy), 0);
    tick();
    rst_n = 1; a_rdy = 1;
    qa.push_back(mk(0, 0, 0)); qa.push_back(mk(1, 1, 1));
    tick();
    chk("rs_latency_valid", int'(a_valid), 1);
    chk("rs_latency_sel", int'(a_sel), 0);
    tick();
    a_avail = 0;
    tick();

    // NRET=4 gap skipping
    nb0 = nb_beats;
    qb.push_back(mk(1, 0, 0)); qb.push_back(mk(3, 1, 1));
    run_b(4'b1010, 2);
    chk("b1010_beats", nb_beats - nb0, 2);
    qb.push_back(mk(0, 0, 0)); qb.push_back(mk(1, 0, 0)); qb.push_back(mk(2, 1, 1));
    run_b(4'b0111, 3);
    qb.push_back(mk(3, 1, 1));
    run_b(4'b1000, 1);
    qb.push_back(mk(0, 0, 0)); qb.push_back(mk(1, 0, 0));
    qb.push_back(mk(2, 0, 0)); qb.push_back(mk(3, 1, 1));
    run_b(4'b1111, 4);

    tick();
    tick();
    chk("qa_drained", qa.size(), 0);
    chk("qb_drained", qb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
